// File: rtl/program_loader_pkg.sv
// Shared constants for the Brainfuck program path: loader FSM encoding,
// the eight command bytes and the program terminator.
package program_loader_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_TERM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] C_PLUS  = 8'h2B;
    localparam logic [7:0] C_MINUS = 8'h2D;
    localparam logic [7:0] C_LEFT  = 8'h3C;
    localparam logic [7:0] C_RIGHT = 8'h3E;
    localparam logic [7:0] C_OPEN  = 8'h5B;
    localparam logic [7:0] C_CLOSE = 8'h5D;
    localparam logic [7:0] C_OUT   = 8'h2E;
    localparam logic [7:0] C_IN    = 8'h2C;

    localparam logic [7:0] C_TERM = 8'h00;

endpackage

// File: rtl/program_loader_if.sv
// Source-byte handshake plus program-memory write port of the loader.
// A byte transfers on a rising edge where i_valid && o_ready; the source holds
// i_data while i_valid is high and not yet accepted, o_ready never depends on i_valid.
interface program_loader_if #(
    parameter int c_addr_width = 8,
    parameter int c_data_width = 8
);
    logic                    i_valid;
    logic [7:0]              i_data;
    logic                    o_ready;
    logic                    o_mem_enable;
    logic [c_addr_width-1:0] o_mem_addr;
    logic [c_data_width-1:0] o_mem_data;

    modport master (
        output i_valid, i_data,
        input  o_ready, o_mem_enable, o_mem_addr, o_mem_data
    );

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_mem_enable, o_mem_addr, o_mem_data
    );
endinterface

// File: rtl/program_loader_classify.sv
// Combinational Brainfuck byte classifier: command membership and bracket kind.
module bf_cmd_classify
    import program_loader_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_cmd_o,
    output logic       is_open_o,
    output logic       is_close_o
);
    assign is_open_o  = (byte_i == C_OPEN);
    assign is_close_o = (byte_i == C_CLOSE);
    assign is_cmd_o   = (byte_i == C_PLUS)  || (byte_i == C_MINUS) ||
                        (byte_i == C_LEFT)  || (byte_i == C_RIGHT) ||
                        (byte_i == C_OUT)   || (byte_i == C_IN)    ||
                        is_open_o || is_close_o;
endmodule

// File: rtl/program_loader.sv
// Filters a Brainfuck byte stream into program memory, appends the 0x00
// terminator and reports length, overflow and bracket-balance status.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int c_addr_width = 8,
    parameter int c_data_width = 8,
    parameter int c_nest_width = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    program_loader_if.slave         bus,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [c_addr_width-1:0] o_length,
    output logic                    o_err_overflow,
    output logic                    o_err_bracket,
    output logic [1:0]              o_state
);
    localparam logic [c_addr_width-1:0] C_MAX = '1;

    logic [1:0]              state_q, state_d;
    logic [c_addr_width-1:0] count_q, count_d;
    logic [c_nest_width-1:0] nest_q, nest_d;
    logic [c_addr_width-1:0] length_q, length_d;
    logic                    ovf_q, ovf_d;
    logic                    brk_q, brk_d;
    logic                    ready_q, busy_q, done_q;
    logic                    mem_en_q, mem_en_d;
    logic [c_addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [c_data_width-1:0] mem_data_q, mem_data_d;

    logic is_cmd, is_open, is_close, accept, go_term;

    bf_cmd_classify u_classify (
        .byte_i     (bus.i_data),
        .is_cmd_o   (is_cmd),
        .is_open_o  (is_open),
        .is_close_o (is_close)
    );

    assign accept = bus.i_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        nest_d     = nest_q;
        length_d   = length_q;
        ovf_d      = ovf_q;
        brk_d      = brk_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        go_term    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d  = S_LOAD;
                    count_d  = '0;
                    nest_d   = '0;
                    length_d = '0;
                    ovf_d    = 1'b0;
                    brk_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (bus.i_data == C_TERM) begin
                        go_term = 1'b1;
                    end else if (is_cmd) begin
                        if (count_q == C_MAX) begin
                            ovf_d   = 1'b1;
                            go_term = 1'b1;
                        end else begin
                            mem_en_d   = 1'b1;
                            mem_addr_d = count_q;
                            mem_data_d = c_data_width'(bus.i_data);
                            count_d    = count_q + 1'b1;
                            if (is_open) begin
                                if (&nest_q) brk_d = 1'b1;
                                else         nest_d = nest_q + 1'b1;
                            end
                            if (is_close) begin
                                if (nest_q == '0) brk_d = 1'b1;
                                else              nest_d = nest_q - 1'b1;
                            end
                        end
                    end
                end
                // Terminator strobe is issued on entry so it lands in the TERM cycle.
                if (go_term) begin
                    state_d    = S_TERM;
                    mem_en_d   = 1'b1;
                    mem_addr_d = count_q;
                    mem_data_d = '0;
                end
            end
            S_TERM: begin
                length_d = count_q;
                if (nest_q != '0) brk_d = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            nest_q     <= '0;
            length_q   <= '0;
            ovf_q      <= 1'b0;
            brk_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            nest_q     <= nest_d;
            length_q   <= length_d;
            ovf_q      <= ovf_d;
            brk_q      <= brk_d;
            ready_q    <= (state_d == S_LOAD);
            busy_q     <= (state_d == S_LOAD) || (state_d == S_TERM);
            done_q     <= (state_d == S_DONE);
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_mem_enable = mem_en_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_data   = mem_data_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_length         = length_q;
    assign o_err_overflow   = ovf_q;
    assign o_err_bracket    = brk_q;
    assign o_state          = state_q;
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer end of the program memory interface: streams Brainfuck source bytes in over a valid/ready handshake.
- Strips everything that is not one of the 8 commands and writes the surviving commands sequentially into program memory through a single write port (enable/addr/data).
- Appends a 0x00 terminator, then reports program length plus overflow and bracket-balance errors.
- Sits between the host/UART byte source and the program memory, ahead of the CPU core.

Parameters:
c_addr_width, 8, program memory address width; capacity = 2**c_addr_width locations, the last one always reserved for the terminator.
c_data_width, 8, memory word width; must be >= 8; commands zero-extended.
c_nest_width, 8, width of the bracket nesting counter.

Ports:
i_clock  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_start  input  1  single-cycle pulse: begin a new load (ignored while in LOAD or TERM)
i_valid  input  1  source byte valid
i_data  input  8  source byte (ASCII)
o_ready  output  1  loader can accept a byte this cycle
o_mem_enable  output  1  write strobe to program memory, one cycle per word
o_mem_addr  output  c_addr_width  write address
o_mem_data  output  c_data_width  write data
o_busy  output  1  high in LOAD and TERM
o_done  output  1  high in DONE
o_length  output  c_addr_width  number of commands stored, terminator excluded
o_err_overflow  output  1  program exceeded capacity
o_err_bracket  output  1  unmatched '[' or ']' detected

Behaviour:
- Reset (async, i_reset_n low):
  - State = IDLE.
  - All outputs 0; count, nesting counter and error flags cleared.
- All outputs are registered.
- States: IDLE, LOAD, TERM, DONE.
- IDLE:
  - o_ready = 0.
  - i_start -> LOAD; clears count, nest, o_length, both error flags.
- LOAD:
  - o_ready = 1; a byte is accepted when i_valid && o_ready.
  - Accepted command byte ('+' 0x2B, '-' 0x2D, '<' 0x3C, '>' 0x3E, '[' 0x5B, ']' 0x5D, '.' 0x2E, ',' 0x2C) with count < 2**c_addr_width-1:
    - In the next cycle, o_mem_enable = 1, o_mem_addr = count, o_mem_data = byte.
    - count increments.
  - Accepted command byte with count == 2**c_addr_width-1:
    - Not written.
    - o_err_overflow set; -> TERM.
  - Accepted 0x00: end of program; -> TERM.
  - Any other accepted byte is discarded: no write, no state change.
  - '[' increments nest; at saturation (all ones) it sets o_err_bracket and nest holds.
  - ']' with nest == 0 sets o_err_bracket; nest stays 0; the byte is still written.
  - ']' with nest > 0 decrements nest.
- TERM (exactly one cycle):
  - o_ready = 0.
  - o_mem_enable = 1, o_mem_addr = count, o_mem_data = 0.
  - If nest != 0, set o_err_bracket.
  - o_length = count.
  - -> DONE.
- DONE:
  - o_done = 1; o_length and the error flags hold.
  - o_ready = 0.
  - i_start -> LOAD, clearing as in IDLE.
- Write latency: one cycle from acceptance to strobe. Addr/data are stable for the whole strobe cycle; o_mem_enable is never high for two cycles on the same address.
- o_mem_addr/o_mem_data hold their last value when o_mem_enable = 0.
- i_start in LOAD or TERM is ignored.
- i_valid outside LOAD is ignored; no byte is consumed.
- Reset mid-load:
  - Immediate return to IDLE; o_mem_enable drops asynchronously.
  - Partially written memory contents are not cleaned up.
- Maximum program: 2**c_addr_width-1 commands plus terminator; o_length saturates at 2**c_addr_width-1.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - the eight command byte constants;
  - the terminator value 0x00.
- The CPU decoder uses the same package.
- One natural sub-module, bf_cmd_classify: combinational byte -> {is_cmd, is_open, is_close}.
- Everything else stays in program_loader.

Test Plan:
- Start, stream "+[->+<]" then 0x00 -> 7 writes at addrs 0..6 with those bytes, then 0x00 at addr 7; o_done=1, o_length=7, no errors.
- Start, stream "a+ b\n-" then 0x00 -> only '+' @0 and '-' @1 written, terminator @2, o_length=2.
- c_addr_width=4: stream 20 '+' -> writes at addrs 0..14, o_err_overflow=1 on the 16th '+', terminator @15, o_length=15, o_ready low from TERM on.
- Stream "]" then 0x00 -> ']' written @0, o_err_bracket=1. Restart, stream "[[" then 0x00 -> o_err_bracket=1 set in TERM, o_length=2.
- Toggle i_valid randomly, then pull i_reset_n low in the middle of LOAD -> o_mem_enable=0 and all outputs 0 immediately. A following start+load behaves as from a fresh reset.
- Issue i_start during LOAD, and i_valid while in IDLE/DONE -> no effect on count, no writes, no bytes consumed (o_ready stays 0).
